// File: rtl/cmd_bits.sv
// Shared calculator command encoding: bit positions inside a command byte,
// plus the state type used by the command master that replays those commands.
package cmd_bits;

  localparam int b_op_1   = 0;
  localparam int b_op_2   = 1;
  localparam int b_tx     = 2;
  localparam int b_addop  = 3;
  localparam int b_addres = 4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BUSY,
    CMD,
    OP1,
    OP2,
    WAIT_RDY,
    RSP
  } dev_master_state_t;

  // Picks the next phase after a command or operand beat: remaining operands
  // first, then the optional read-back, otherwise the transaction is done.
  function automatic dev_master_state_t phase_after(input logic op1,
                                                    input logic op2,
                                                    input logic tx);
    if (op1)      return OP1;
    else if (op2) return OP2;
    else if (tx)  return WAIT_RDY;
    else          return IDLE;
  endfunction

endpackage

// File: rtl/dev_master_if.sv
// Request, response and device-side signals of the calculator command master.
// The master modport is the command master's view; slave is everyone else.
interface dev_master_if #(parameter int DW = 8);

  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_cmd;
  logic [DW-1:0] req_op1;
  logic [DW-1:0] req_op2;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  logic          dev_cs;
  logic [DW-1:0] dev_din;
  logic          dev_busy;
  logic [DW-1:0] dev_dout;
  logic          dev_drdy;

  modport master (
    input  req_valid, req_cmd, req_op1, req_op2,
    output req_ready,
    output rsp_valid, rsp_data, rsp_err,
    input  rsp_ready,
    output dev_cs, dev_din,
    input  dev_busy, dev_dout, dev_drdy
  );

  modport slave (
    output req_valid, req_cmd, req_op1, req_op2,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_err,
    output rsp_ready,
    input  dev_cs, dev_din,
    output dev_busy, dev_dout, dev_drdy
  );

endinterface

// File: rtl/dev_master.sv
// Replays one buffered calculator request to dev_fsm as a cs/din beat sequence
// and, for read-back commands, returns the device result with a timeout guard.
module dev_master
  import cmd_bits::*;
#(
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input logic         clk,
  input logic         rst,
  dev_master_if.master bus
);

  // A zero TIMEOUT disables the guard, but the counter still needs one bit.
  localparam int            CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  dev_master_state_t state, state_next;

  logic [DW-1:0] cmd_q, op1_q, op2_q;
  logic [DW-1:0] rsp_data_q;
  logic          rsp_err_q;
  logic [CW-1:0] cnt_q;
  logic          timeout_hit;

  logic          req_ready_c;
  logic          rsp_valid_c;
  logic          dev_cs_c;
  logic [DW-1:0] dev_din_c;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd_q      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state <= state_next;

      if (state == IDLE && bus.req_valid) begin
        cmd_q <= bus.req_cmd;
        op1_q <= bus.req_op1;
        op2_q <= bus.req_op2;
      end

      // drdy is checked before the limit so a last-cycle result still counts.
      if (state == WAIT_RDY) begin
        if (bus.dev_drdy) begin
          rsp_data_q <= bus.dev_dout;
          rsp_err_q  <= 1'b0;
        end else if (timeout_hit) begin
          rsp_data_q <= '0;
          rsp_err_q  <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  // Device outputs come only from the state and the latched request, never
  // from the live request inputs.
  always_comb begin
    state_next  = state;
    req_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    dev_cs_c    = 1'b0;
    dev_din_c   = '0;

    case (state)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!bus.dev_busy) state_next = CMD;
      end
      CMD: begin
        dev_cs_c   = 1'b1;
        dev_din_c  = cmd_q;
        state_next = phase_after(cmd_q[b_op_1], cmd_q[b_op_2], cmd_q[b_tx]);
      end
      OP1: begin
        dev_din_c  = op1_q;
        state_next = phase_after(1'b0, cmd_q[b_op_2], cmd_q[b_tx]);
      end
      OP2: begin
        dev_din_c  = op2_q;
        state_next = phase_after(1'b0, 1'b0, cmd_q[b_tx]);
      end
      WAIT_RDY: begin
        if (bus.dev_drdy || timeout_hit) state_next = RSP;
      end
      RSP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.dev_cs    = dev_cs_c;
  assign bus.dev_din   = dev_din_c;

endmodule

// File: tb/tb_dev_master.sv
// Randomized bench for dev_master: each transaction's beat sequence, response
// cycle and payload are derived from the command bits with plain arithmetic.
module tb_dev_master;
  import cmd_bits::*;

  localparam int DW      = 8;
  localparam int TIMEOUT = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  always #5 clk = ~clk;

  dev_master_if #(.DW(DW)) bus ();

  dev_master #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic drive_quiet();
    bus.req_valid = 1'b0;
    bus.req_cmd   = '0;
    bus.req_op1   = '0;
    bus.req_op2   = '0;
    bus.rsp_ready = 1'b0;
    bus.dev_busy  = 1'b0;
    bus.dev_dout  = '0;
    bus.dev_drdy  = 1'b0;
  endtask

  // Idle cycles with noisy device inputs; nothing may leave the block.
  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.dev_busy = 1'($urandom);
      bus.dev_drdy = 1'($urandom);
      bus.dev_dout = DW'($urandom);
      @(negedge clk);
      check_output({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      check_output({tag, "_cs"},        32'(bus.dev_cs),    32'd0);
      check_output({tag, "_din"},       32'(bus.dev_din),   32'd0);
      check_output({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    end
    bus.dev_busy = 1'b0;
    bus.dev_drdy = 1'b0;
  endtask

  // Called at a falling edge with the block idle. Cycle k is the cycle that
  // starts k-1 edges after the accepting edge.
  task automatic apply_stimulus(input logic [DW-1:0] cmd, input logic [DW-1:0] op1,
                                input logic [DW-1:0] op2, input int busy_cycles,
                                input int drdy_delay, input logic [DW-1:0] rdata,
                                input int stall, input bit pend);
    logic [DW-1:0] seq[$];
    logic [DW-1:0] exp_data;
    logic [DW-1:0] exp_din;
    logic          exp_err;
    logic          tx;
    logic          exp_rsp;
    int cmd_cyc, entry, rsp_cyc, end_cyc;

    tx = cmd[b_tx];
    seq = {};
    seq.push_back(cmd);
    if (cmd[b_op_1]) seq.push_back(op1);
    if (cmd[b_op_2]) seq.push_back(op2);
    cmd_cyc = busy_cycles + 2;
    entry   = cmd_cyc + seq.size();
    rsp_cyc = 0;
    exp_data = '0;
    exp_err  = 1'b0;
    if (tx) begin
      if (drdy_delay <= TIMEOUT) begin
        rsp_cyc  = entry + drdy_delay + 1;
        exp_data = rdata;
      end else begin
        rsp_cyc  = entry + TIMEOUT + 1;
        exp_err  = 1'b1;
      end
      end_cyc = rsp_cyc + stall + 1;
    end else begin
      end_cyc = entry;
    end

    bus.req_valid = 1'b1;
    bus.req_cmd   = cmd;
    bus.req_op1   = op1;
    bus.req_op2   = op2;

    for (int k = 1; k <= end_cyc; k++) begin
      @(posedge clk); #1;
      bus.req_valid = pend && (k < end_cyc);
      bus.req_cmd   = DW'($urandom);
      bus.req_op1   = DW'($urandom);
      bus.req_op2   = DW'($urandom);
      if (k <= busy_cycles)          bus.dev_busy = 1'b1;
      else if (k == busy_cycles + 1) bus.dev_busy = 1'b0;
      else                           bus.dev_busy = 1'($urandom);
      bus.dev_drdy = (tx && k == entry + drdy_delay) || (k == cmd_cyc);
      bus.dev_dout = (k == entry + drdy_delay) ? rdata : DW'($urandom);
      if (tx && k >= rsp_cyc) bus.rsp_ready = (k >= rsp_cyc + stall);
      else                    bus.rsp_ready = 1'($urandom);
      @(negedge clk);

      exp_din = (k >= cmd_cyc && k < entry) ? seq[k - cmd_cyc] : '0;
      exp_rsp = tx && k >= rsp_cyc && k < end_cyc;
      check_output("dev_cs",    32'(bus.dev_cs),    32'(k == cmd_cyc));
      check_output("dev_din",   32'(bus.dev_din),   32'(exp_din));
      check_output("req_ready", 32'(bus.req_ready), 32'(k == end_cyc));
      check_output("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp));
      if (exp_rsp) begin
        check_output("rsp_data", 32'(bus.rsp_data), 32'(exp_data));
        check_output("rsp_err",  32'(bus.rsp_err),  32'(exp_err));
      end
    end
    drive_quiet();
  endtask

  // Starts a cmd+op1+op2+tx request and resets the block during the op1 beat.
  task automatic reset_mid_operand();
    logic [DW-1:0] cmd;
    cmd = DW'((1 << b_op_1) | (1 << b_op_2) | (1 << b_tx));
    bus.req_valid = 1'b1;
    bus.req_cmd   = cmd;
    bus.req_op1   = 8'hA5;
    bus.req_op2   = 8'h5A;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      rst = (k == 3);
      @(negedge clk);
    end
    check_output("rst_pre_op1_din", 32'(bus.dev_din), 32'hA5);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("rst_cs",        32'(bus.dev_cs),    32'd0);
    check_output("rst_din",       32'(bus.dev_din),   32'd0);
    check_output("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check_output("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    idle_cycles(6, "post_rst");
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    drive_quiet();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_req_ready", 32'(bus.req_ready), 32'd1);
    check_output("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_output("reset_rsp_data",  32'(bus.rsp_data),  32'd0);
    check_output("reset_rsp_err",   32'(bus.rsp_err),   32'd0);
    check_output("reset_cs",        32'(bus.dev_cs),    32'd0);
    check_output("reset_din",       32'(bus.dev_din),   32'd0);
    rst = 1'b0;
    idle_cycles(2, "idle0");

    $display("[TB] write-only command with two operands");
    apply_stimulus(DW'((1 << b_op_1) | (1 << b_op_2) | (1 << b_addop)),
                   8'h12, 8'h34, 0, 0, 8'h00, 0, 1'b0);
    idle_cycles(3, "after_wr");

    $display("[TB] read-back command, drdy two cycles after op1");
    apply_stimulus(DW'((1 << b_op_1) | (1 << b_addres) | (1 << b_tx)),
                   8'h05, 8'h77, 0, 1, 8'h4B, 3, 1'b0);

    $display("[TB] device busy for four cycles");
    apply_stimulus(DW'((1 << b_op_2) | (1 << b_tx)), 8'h00, 8'h9C, 4, 0, 8'hC3, 0, 1'b0);

    $display("[TB] timeout and last-cycle drdy");
    apply_stimulus(DW'(1 << b_tx), 8'h00, 8'h00, 0, TIMEOUT + 5, 8'hEE, 1, 1'b0);
    apply_stimulus(DW'(1 << b_tx), 8'h00, 8'h00, 1, TIMEOUT, 8'h3D, 0, 1'b0);
    apply_stimulus(DW'((1 << b_op_1) | (1 << b_tx)), 8'h21, 8'h00, 0, TIMEOUT + 1, 8'h99, 2, 1'b0);

    $display("[TB] reset during op1");
    reset_mid_operand();
    apply_stimulus(DW'((1 << b_op_1) | (1 << b_op_2) | (1 << b_tx)),
                   8'h11, 8'h22, 0, 0, 8'h33, 0, 1'b0);

    $display("[TB] response stalled with a request pending");
    apply_stimulus(DW'((1 << b_op_1) | (1 << b_tx)), 8'h44, 8'h00, 0, 2, 8'h6E, 5, 1'b1);
    apply_stimulus(DW'(1 << b_op_2), 8'h00, 8'h55, 0, 0, 8'h00, 0, 1'b0);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 40; t++) begin
      apply_stimulus(DW'($urandom), DW'($urandom), DW'($urandom),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, TIMEOUT + 2)),
                     DW'($urandom), int'($urandom_range(0, 4)), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)), "gap");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/dev_master.md
# dev_master

Hardware command master sitting directly upstream of the calculator device FSM `dev_fsm`. It accepts one buffered calculator request at a time on a valid/ready interface and replays it to the device as a cycle-exact cs/din transaction: command, optional op_1, optional op_2. When the command requests a read-back (`b_tx`), it waits for `drdy`, captures `dout` and returns it on a valid/ready response port, with a timeout guard.

## Interface
- `DW`, 8: data width; must match `dev_fsm` `DW`.
- `TIMEOUT`, 255: maximum cycles spent waiting for `drdy`; 0 disables the timeout.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_cmd` in DW: command byte, bit positions from `cmd_bits`.
- `req_op1` in DW: operand 1, used if `req_cmd[b_op_1]`.
- `req_op2` in DW: operand 2, used if `req_cmd[b_op_2]`.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_data` out DW: captured device result.
- `rsp_err` out 1: 1 = timeout, data invalid.
- `dev_cs` out 1: to `dev_fsm.cs`.
- `dev_din` out DW: to `dev_fsm.din`.
- `dev_busy` in 1: from `dev_fsm.busy`.
- `dev_dout` in DW: from `dev_fsm.dout`.
- `dev_drdy` in 1: from `dev_fsm.drdy`.

## Operation
- FSM states: IDLE, WAIT_BUSY, CMD, OP1, OP2, WAIT_RDY, RSP.
- IDLE: `req_ready=1`. On `req_valid&req_ready`, latch cmd/op1/op2 into internal registers, then go to WAIT_BUSY.
- WAIT_BUSY: stay while `dev_busy=1`. When `dev_busy=0`, go to CMD.
- CMD: `dev_cs=1`, `dev_din=cmd`. Next state is OP1 if `cmd[b_op_1]`, else OP2 if `cmd[b_op_2]`, else WAIT_RDY if `cmd[b_tx]`, else IDLE.
- OP1: `dev_cs=0`, `dev_din=op1`. Next state is OP2 if `b_op_2`, else WAIT_RDY if `b_tx`, else IDLE.
- OP2: `dev_din=op2`. Next state is WAIT_RDY if `b_tx`, else IDLE.
- WAIT_RDY: sample `dev_drdy` every cycle.
  - On `dev_drdy=1`, capture `dev_dout` into `rsp_data`, set `rsp_err=0`, go to RSP.
  - Otherwise increment the timeout counter, width `$clog2(TIMEOUT+1)`, cleared on entry.
  - If the counter reaches TIMEOUT (TIMEOUT≠0): `rsp_data=0`, `rsp_err=1`, go to RSP.
- RSP: `rsp_valid=1`; `rsp_data`/`rsp_err` held stable. On `rsp_ready`, go to IDLE.
- Commands without `b_tx` produce no response.
- `dev_cs` and `dev_din` are decoded from the state register plus latched request registers only. There is no combinational path from `req_*` to `dev_*`.
- `dev_din=0` in IDLE, WAIT_BUSY, WAIT_RDY and RSP.
- Reset values: state=IDLE, `req_ready=1`, `rsp_valid=0`, `rsp_data=0`, `rsp_err=0`, `dev_cs=0`, `dev_din=0`, counter=0, latched registers=0.

## Timing
- `req_ready` is high only in IDLE; requests are never accepted back-to-back in one cycle.
- Minimum path, accept at edge 0:
  - cycle 1: WAIT_BUSY
  - cycle 2: CMD
  - cycle 3: OP1
  - cycle 4: OP2
  - cycle 5: first `drdy` sample
  - A full cmd+2 ops transaction with `drdy` in cycle 5 gives `rsp_valid` in cycle 6.
- `dev_cs` is high for exactly one cycle per transaction. Operands follow on consecutive cycles with no gaps.
- `dev_drdy`/`dev_busy` are ignored outside WAIT_RDY/WAIT_BUSY. `drdy` during CMD/OP states is not recorded.
- Timeout: with no `drdy`, `rsp_valid` rises TIMEOUT+1 cycles after WAIT_RDY entry.
- `drdy` in the same cycle the counter hits TIMEOUT: success wins, `rsp_err=0`.
- `rst` in any state, including mid-operand: the next cycle is IDLE with reset values. The in-flight request is dropped and no response is issued.
- `rsp_valid` held with `rsp_ready=0` indefinitely: the block stalls in RSP and `req_ready` stays 0.

## Structure
- Command bit positions (`b_op_1`, `b_op_2`, `b_tx`, `b_addop`, `b_addres`) come from the existing `cmd_bits` package.
- Add the state enum `dev_master_state_t` to `cmd_bits`.
- Single module, no sub-modules. The timeout counter is inline.

## Test plan
- Cmd `(1<<b_op_1)|(1<<b_op_2)|(1<<b_addop)`, op1=0x12, op2=0x34, `busy=0`:
  - `dev_cs` high 1 cycle with `din`=cmd, then `din`=0x12, then 0x34.
  - Return to IDLE, no `rsp_valid`.
- Cmd `(1<<b_op_1)|(1<<b_addres)|(1<<b_tx)`, op1=0x05, model returns `dout`=0x4B with `drdy` 2 cycles after OP1:
  - `rsp_data`=0x4B, `rsp_err`=0.
  - `rsp_valid` held until `rsp_ready`.
- `dev_busy` high for 4 cycles after accept:
  - `dev_cs` asserts on the first cycle after `busy` falls.
  - `req_ready`=0 throughout.
- TIMEOUT=3, tx command, `drdy` never asserted:
  - `rsp_valid` 4 cycles after WAIT_RDY entry, `rsp_err`=1, `rsp_data`=0.
- `rst` asserted during OP1:
  - Next cycle: `dev_cs`=0, `dev_din`=0, `req_ready`=1, no response.
  - A following request completes normally.
- `rsp_ready` held low 5 cycles with a new `req_valid` pending:
  - Request not accepted until the cycle after the response handshake.
